// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: applies one of eight logic ops to two operands,
// SLICE bits per cycle, LSB slice first, under a start/done handshake.
module seq_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             zero
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_slice
            $error("seq_logic_unit: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    logic [1:0]       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] r_reg;
    logic             zero_reg;
    logic [WIDTH-1:0] func_res;
    logic [WIDTH-1:0] r_next;
    logic             last_slice;

    // Full-width result from the latched operands; only the active slice is committed.
    always_comb begin
        func_res = '0;
        case (op_reg)
            3'b000:  func_res = a_reg & b_reg;
            3'b001:  func_res = a_reg | b_reg;
            3'b010:  func_res = a_reg ^ b_reg;
            3'b011:  func_res = ~(a_reg | b_reg);
            3'b100:  func_res = ~(a_reg & b_reg);
            3'b101:  func_res = ~(a_reg ^ b_reg);
            3'b110:  func_res = a_reg & ~b_reg;
            default: func_res = ~a_reg;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign r_next[gi*SLICE +: SLICE] = (cnt_reg == CW'(gi))
                                             ? func_res[gi*SLICE +: SLICE]
                                             : r_reg[gi*SLICE +: SLICE];
        end
    endgenerate

    assign last_slice = (cnt_reg == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            r_reg     <= '0;
            zero_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        op_reg    <= op;
                        a_reg     <= a;
                        b_reg     <= b;
                        r_reg     <= '0;
                        cnt_reg   <= '0;
                        state_reg <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_reg   <= r_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (last_slice) begin
                        zero_reg  <= (r_next == '0);
                        state_reg <= S_DONE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign ready = (state_reg == S_IDLE);
    assign busy  = (state_reg == S_RUN);
    assign done  = (state_reg == S_DONE);
    assign r     = r_reg;
    assign zero  = zero_reg;

endmodule

// File: tb/tb_seq_logic_unit.sv
// Bench for seq_logic_unit in three configurations (32/8, 32/32, 16/4) with a result scoreboard.
module tb_seq_logic_unit;

    typedef struct {
        int          dut;
        logic [31:0] r;
        logic        z;
    } sb_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        logic        exp_z;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_s [3];
    logic [2:0]  op_s    [3];
    logic [31:0] a_s     [3];
    logic [31:0] b_s     [3];
    logic        ready_s [3];
    logic        busy_s  [3];
    logic        done_s  [3];
    logic        zero_s  [3];
    logic [31:0] r_s     [3];
    logic [31:0] r0, r1;
    logic [15:0] r2;

    int n_checks = 0;
    int n_errors = 0;
    sb_t sbq[$];
    sb_t mon_e;
    vec_t vecs[8];
    int lat[3] = '{4, 1, 4};

    always #5 clk = ~clk;

    seq_logic_unit u0 (
        .clk(clk), .reset(reset), .start(start_s[0]), .op(op_s[0]), .a(a_s[0]), .b(b_s[0]),
        .ready(ready_s[0]), .busy(busy_s[0]), .done(done_s[0]), .r(r0), .zero(zero_s[0])
    );
    seq_logic_unit #(.WIDTH(32), .SLICE(32)) u1 (
        .clk(clk), .reset(reset), .start(start_s[1]), .op(op_s[1]), .a(a_s[1]), .b(b_s[1]),
        .ready(ready_s[1]), .busy(busy_s[1]), .done(done_s[1]), .r(r1), .zero(zero_s[1])
    );
    seq_logic_unit #(.WIDTH(16), .SLICE(4)) u2 (
        .clk(clk), .reset(reset), .start(start_s[2]), .op(op_s[2]), .a(a_s[2][15:0]), .b(b_s[2][15:0]),
        .ready(ready_s[2]), .busy(busy_s[2]), .done(done_s[2]), .r(r2), .zero(zero_s[2])
    );

    assign r_s[0] = r0;
    assign r_s[1] = r1;
    assign r_s[2] = {16'h0000, r2};

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a | b);
            3'd4:    return ~(a & b);
            3'd5:    return ~(a ^ b);
            3'd6:    return a & ~b;
            default: return ~a;
        endcase
    endfunction

    // Scoreboard: every done pops one expected record; a done with nothing queued is an error.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (done_s[d] === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: dut %0d got done=1 expected done=0", d);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("dut_id", 32'(d), 32'(mon_e.dut));
                    chk("result", r_s[d], mon_e.r);
                    chk("zero", {31'b0, zero_s[d]}, {31'b0, mon_e.z});
                    $display("txn dut=%0d r=%h zero=%b exp_r=%h exp_zero=%b",
                             d, r_s[d], zero_s[d], mon_e.r, mon_e.z);
                end
            end
        end
    end

    task automatic do_txn(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_z);
        int cyc;
        sb_t e;
        @(negedge clk);
        chk("ready_before", {31'b0, ready_s[d]}, 32'd1);
        start_s[d] = 1'b1;
        op_s[d] = op;
        a_s[d] = a;
        b_s[d] = b;
        e.dut = d;
        e.r = exp_r;
        e.z = exp_z;
        sbq.push_back(e);
        @(negedge clk);
        start_s[d] = 1'b0;
        a_s[d] = $urandom;
        b_s[d] = $urandom;
        op_s[d] = 3'($urandom);
        cyc = 0;
        while (done_s[d] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(lat[d]));
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done_s[d]}, 32'd0);
        chk("ready_after", {31'b0, ready_s[d]}, 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb, m, ex;
        int cyc;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0; op_s[d] = 3'd0; a_s[d] = '0; b_s[d] = '0;
        end
        vecs[0] = '{3'b011, 32'h0000FFFF, 32'h00FF00FF, 32'hFF000000, 1'b0};
        vecs[1] = '{3'b010, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b1};
        vecs[2] = '{3'b110, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0};
        vecs[3] = '{3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
        vecs[4] = '{3'b001, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0};
        vecs[5] = '{3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[6] = '{3'b101, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF00FF00F, 1'b0};
        vecs[7] = '{3'b111, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_ready", {31'b0, ready_s[d]}, 32'd1);
            chk("rst_busy", {31'b0, busy_s[d]}, 32'd0);
            chk("rst_done", {31'b0, done_s[d]}, 32'd0);
            chk("rst_r", r_s[d], 32'd0);
            chk("rst_zero", {31'b0, zero_s[d]}, 32'd0);
        end

        for (int i = 0; i < 8; i++)
            do_txn(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_r, vecs[i].exp_z);

        // Operand isolation and start-while-busy.
        @(negedge clk);
        start_s[0] = 1'b1; op_s[0] = 3'b011; a_s[0] = '0; b_s[0] = '0;
        sbq.push_back('{0, 32'hFFFFFFFF, 1'b0});
        @(negedge clk);
        start_s[0] = 1'b0; a_s[0] = 32'hFFFFFFFF;
        chk("iso_busy", {31'b0, busy_s[0]}, 32'd1);
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        cyc = 0;
        while (done_s[0] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("iso_done_seen", {31'b0, done_s[0]}, 32'd1);
        repeat (2) @(negedge clk);
        chk("iso_not_queued_ready", {31'b0, ready_s[0]}, 32'd1);
        chk("iso_not_queued_busy", {31'b0, busy_s[0]}, 32'd0);

        // Zero set by a result, then reset mid-RUN clears it and aborts.
        do_txn(0, 3'b010, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h0, 1'b1);
        @(negedge clk);
        start_s[0] = 1'b1; op_s[0] = 3'b000; a_s[0] = 32'hFFFFFFFF; b_s[0] = 32'hFFFFFFFF;
        @(negedge clk);
        start_s[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_r", r_s[0], 32'd0);
        chk("abort_zero", {31'b0, zero_s[0]}, 32'd0);
        chk("abort_ready", {31'b0, ready_s[0]}, 32'd1);
        chk("abort_busy", {31'b0, busy_s[0]}, 32'd0);
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_s[0] === 1'b1) cyc++;
        end
        chk("abort_no_done", 32'(cyc), 32'd0);

        // Reset and start at the same edge: reset wins.
        @(negedge clk);
        reset = 1'b1; start_s[0] = 1'b1; op_s[0] = 3'b001; a_s[0] = 32'h1; b_s[0] = 32'h2;
        @(negedge clk);
        reset = 1'b0; start_s[0] = 1'b0;
        chk("rst_start_ready", {31'b0, ready_s[0]}, 32'd1);
        chk("rst_start_busy", {31'b0, busy_s[0]}, 32'd0);
        @(negedge clk);
        chk("rst_start_still_idle", {31'b0, ready_s[0]}, 32'd1);

        // Random sweep across all ops and all three configurations.
        for (int d = 0; d < 3; d++) begin
            m = (d == 2) ? 32'h0000FFFF : 32'hFFFFFFFF;
            for (int op = 0; op < 8; op++) begin
                for (int k = 0; k < 200; k++) begin
                    ra = $urandom;
                    rb = $urandom;
                    ex = model(3'(op), ra, rb) & m;
                    do_txn(d, 3'(op), ra, rb, ex, (ex == 32'd0));
                end
            end
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_logic_unit.md
Name: seq_logic_unit

Overview:
Parametrised, multi-cycle bitwise logic unit that generalises the fixed 32-bit single-function gate array.
- Function is selected at run time from eight logic ops.
- Processes operands SLICE bits per cycle, LSB slice first, under a start/done handshake.
- Sits beside the ALU datapath in the MIPS project and also serves narrow, area-constrained configurations.

Parameters:
WIDTH, 32, operand/result width in bits.
SLICE, 8, bits processed per cycle. WIDTH % SLICE must be 0, otherwise elaboration error. SLICE == WIDTH is legal.

Ports:
clk  input  1  clock, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; accepted only when ready=1.
op  input  3  function select, sampled at accept.
a  input  WIDTH  operand A, sampled at accept.
b  input  WIDTH  operand B, sampled at accept.
ready  output  1  high in IDLE only.
busy  output  1  high in RUN only.
done  output  1  one-cycle pulse: r/zero valid.
r  output  WIDTH  result, held until next accept.
zero  output  1  result == 0, valid with done, held with r.

Behaviour:
- Op encoding:
  - 000 AND, 001 OR, 010 XOR, 011 NOR.
  - 100 NAND, 101 XNOR, 110 ANDN (a & ~b), 111 NOTA (~a, b ignored).
- States: IDLE, RUN, DONE. N = WIDTH/SLICE; slice counter is ceil(log2(N)) bits, minimum 1.
- IDLE (ready=1):
  - start=1 at an edge: latch a, b, op into internal registers; clear r to 0; counter=0; next state RUN.
  - start=0: stay in IDLE.
- RUN (busy=1):
  - Each edge writes r[counter*SLICE +: SLICE] = f(op, a_slice, b_slice) from the latched operands; counter increments.
  - On the edge writing slice N-1: register zero = (complete r == 0); next state DONE.
- DONE: done=1 for exactly this one cycle, ready=0; next edge goes to IDLE unconditionally.
- Latency:
  - Start accepted at edge E0; RUN edges are E1..EN; done is high in the cycle after EN; ready returns after E(N+1).
  - Default config (N=4): done visible 4 cycles after the accept edge; a new start can be accepted at the earliest 5 cycles after the previous one.
- Port inputs (a, b, op) changing after accept have no effect on the in-flight result.
- start while busy or in DONE: ignored, not queued.
- r during RUN is partially written and is not valid; consumers use done only.
- After done, r and zero hold until the next accepted start. Accept clears r but not zero; zero is re-evaluated at EN.
- Reset (any state, including mid-RUN) at an edge:
  - state=IDLE, counter=0, r=0, zero=0, latched operands=0, done=0.
  - In the following cycle: ready=1, busy=0.
  - Aborted operation never produces done.
- reset and start high at the same edge: reset wins; start is not accepted.
- ready, busy and done are decoded from state only (no input-to-output combinational path).
- No arithmetic and no carries: every result bit depends only on the same bit index of a and b.

Test Plan:
- Default params, op=011 NOR, a=0x0000FFFF, b=0x00FF00FF -> done pulses exactly 4 cycles after accept, r=0xFF000000, zero=0, ready high the next cycle.
- op=010 XOR, a=b=0xDEADBEEF -> r=0x00000000, zero=1. Then op=110 ANDN, a=0xFFFFFFFF, b=0x0F0F0F0F -> r=0xF0F0F0F0, zero=0.
- Operand isolation and busy handling:
  - Accept NOR with a=b=0; change a to 0xFFFFFFFF and pulse start 2 cycles after accept -> r=0xFFFFFFFF.
  - Second start ignored; only one done pulse.
- Reset 2 cycles after accept of AND a=b=0xFFFFFFFF -> r=0, zero=0, ready=1 in the cycle after reset, no done pulse in the following 10 cycles.
- Reset and start high on the same edge -> no accept; ready=1 next cycle.
- All 8 ops, random a/b, 200 transactions each -> r matches bitwise reference model. Repeat with WIDTH=32/SLICE=32 (done 1 cycle after accept) and WIDTH=16/SLICE=4 (done 4 cycles after accept).
